// File: rtl/lowampa_trigger_capture_if.sv
// AXI4-Stream beat bundle used for the capture input and the replay output.
// The slave side has no tlast because the capture stage does not use it.
interface lowampa_trigger_capture_if;
   logic [63:0] tdata;
   logic        tvalid;
   logic        tready;
   logic        tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/lowampa_trigger_capture.sv
// Threshold-triggered snapshot of the packed 4x12-bit stream with in-order replay.
// Build option LOWAMPA_TRIG_AUTOREARM_EN: HOLDOFF re-enters FILL instead of IDLE.
module lowampa_trigger_capture #(
   parameter int NPRE    = 16,
   parameter int NPOST   = 48,
   parameter int HOLDOFF = 256
) (
   input  logic                      aclk,
   input  logic                      areset,
   lowampa_trigger_capture_if.slave  s_axis,
   lowampa_trigger_capture_if.master m_axis,
   input  logic [11:0]               thresh_i,
   input  logic                      arm_i,
   output logic                      trig_o,
   output logic                      busy_o
);
   localparam int DEPTH = NPRE + NPOST;
   localparam int AW    = $clog2(DEPTH);
   localparam int IW    = AW + 1;
   localparam int MAXC  = (DEPTH > HOLDOFF) ? DEPTH : HOLDOFF;
   localparam int CW    = $clog2(MAXC + 1);

   localparam logic [CW-1:0] NPRE_LAST  = CW'(NPRE - 1);
   localparam logic [CW-1:0] NPOST_LAST = CW'(NPOST - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
   localparam logic [IW-1:0] ISS_TOTAL  = IW'(DEPTH);
   localparam logic [IW-1:0] ISS_LAST   = IW'(DEPTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_ARMED,
      ST_POST,
      ST_READ,
      ST_HOLD
   } state_t;

`ifdef LOWAMPA_TRIG_AUTOREARM_EN
   localparam state_t REARM_ST = ST_FILL;
`else
   localparam state_t REARM_ST = ST_IDLE;
`endif

   state_t          state_q, state_d;
   logic [AW-1:0]   wp_q, wp_d;
   logic [AW-1:0]   rp_q, rp_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   iss_q, iss_d;
   logic            trig_q, trig_d;
   logic            busy_q;

   logic [63:0]     mem [DEPTH];
   logic [63:0]     rd_data_q;
   logic            rd_vld_q, rd_last_q;

   logic [63:0]     skid0_q, skid0_d, skid1_q, skid1_d;
   logic            skid0_last_q, skid0_last_d, skid1_last_q, skid1_last_d;
   logic [1:0]      skid_cnt_q, skid_cnt_d;

   logic [63:0]     out_data_q, out_data_d;
   logic            out_vld_q, out_vld_d;
   logic            out_last_q, out_last_d;

   logic [3:0]      lane_hit;
   logic            beat_hit;
   logic            wr_en;
   logic            rd_en;
   logic            out_free;
   logic            last_hs;
   logic            push;
   logic [2:0]      occ;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [12:0] ext;
         logic [12:0] mag;
         assign ext           = {s_axis.tdata[16*gi+15], s_axis.tdata[16*gi+4 +: 12]};
         assign mag           = ext[12] ? (13'd0 - ext) : ext;
         assign lane_hit[gi]  = (mag > {1'b0, thresh_i});
      end
   endgenerate

   assign beat_hit = |lane_hit;

   assign out_free = !out_vld_q || m_axis.tready;
   assign last_hs  = out_vld_q && m_axis.tready && out_last_q;
   // Occupancy of read register, skid and output; capped at 3 so an in-flight read always lands.
   assign occ      = {2'b00, rd_vld_q} + {1'b0, skid_cnt_q} + {2'b00, out_vld_q};
   assign rd_en    = (state_q == ST_READ) && (iss_q != ISS_TOTAL) && (occ < 3'd3);

   always_comb begin
      state_d = state_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      cnt_d   = cnt_q;
      iss_d   = iss_q;
      trig_d  = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arm_i) begin
               state_d = ST_FILL;
               wp_d    = '0;
               cnt_d   = '0;
            end
         end
         ST_FILL: begin
            if (s_axis.tvalid) begin
               wr_en = 1'b1;
               wp_d  = wp_q + AW'(1);
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == NPRE_LAST) begin
                  state_d = ST_ARMED;
                  cnt_d   = '0;
               end
            end
         end
         ST_ARMED: begin
            if (s_axis.tvalid) begin
               wr_en = 1'b1;
               wp_d  = wp_q + AW'(1);
               if (beat_hit) begin
                  trig_d = 1'b1;
                  cnt_d  = CW'(1);
                  if (NPOST == 1) begin
                     state_d = ST_READ;
                     rp_d    = wp_q + AW'(1);
                     iss_d   = '0;
                  end else begin
                     state_d = ST_POST;
                  end
               end
            end
         end
         ST_POST: begin
            if (s_axis.tvalid) begin
               wr_en = 1'b1;
               wp_d  = wp_q + AW'(1);
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == NPOST_LAST) begin
                  // The ring is full: the slot after the last write holds the oldest beat.
                  state_d = ST_READ;
                  rp_d    = wp_q + AW'(1);
                  iss_d   = '0;
               end
            end
         end
         ST_READ: begin
            if (rd_en) begin
               rp_d  = rp_q + AW'(1);
               iss_d = iss_q + IW'(1);
            end
            if (last_hs) begin
               cnt_d = '0;
               wp_d  = '0;
               state_d = (HOLDOFF == 0) ? REARM_ST : ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (s_axis.tvalid) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == HOLD_LAST) begin
                  state_d = REARM_ST;
                  cnt_d   = '0;
                  wp_d    = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output register fed first from the skid, then straight from the RAM read register.
   always_comb begin
      skid0_d      = skid0_q;
      skid0_last_d = skid0_last_q;
      skid1_d      = skid1_q;
      skid1_last_d = skid1_last_q;
      skid_cnt_d   = skid_cnt_q;
      out_data_d   = out_data_q;
      out_vld_d    = out_vld_q;
      out_last_d   = out_last_q;
      push         = rd_vld_q;
      if (out_free) begin
         if (skid_cnt_q != 2'd0) begin
            out_data_d   = skid0_q;
            out_last_d   = skid0_last_q;
            out_vld_d    = 1'b1;
            skid0_d      = skid1_q;
            skid0_last_d = skid1_last_q;
            skid_cnt_d   = skid_cnt_q - 2'd1;
         end else if (rd_vld_q) begin
            out_data_d = rd_data_q;
            out_last_d = rd_last_q;
            out_vld_d  = 1'b1;
            push       = 1'b0;
         end else begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
         end
      end
      if (push) begin
         if (skid_cnt_d == 2'd0) begin
            skid0_d      = rd_data_q;
            skid0_last_d = rd_last_q;
         end else begin
            skid1_d      = rd_data_q;
            skid1_last_d = rd_last_q;
         end
         skid_cnt_d = skid_cnt_d + 2'd1;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q      <= ST_IDLE;
         wp_q         <= '0;
         rp_q         <= '0;
         cnt_q        <= '0;
         iss_q        <= '0;
         trig_q       <= 1'b0;
         busy_q       <= 1'b0;
         rd_vld_q     <= 1'b0;
         rd_last_q    <= 1'b0;
         skid0_q      <= '0;
         skid0_last_q <= 1'b0;
         skid1_q      <= '0;
         skid1_last_q <= 1'b0;
         skid_cnt_q   <= '0;
         out_data_q   <= '0;
         out_vld_q    <= 1'b0;
         out_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wp_q         <= wp_d;
         rp_q         <= rp_d;
         cnt_q        <= cnt_d;
         iss_q        <= iss_d;
         trig_q       <= trig_d;
         busy_q       <= (state_d != ST_IDLE);
         rd_vld_q     <= rd_en;
         rd_last_q    <= rd_en && (iss_q == ISS_LAST);
         skid0_q      <= skid0_d;
         skid0_last_q <= skid0_last_d;
         skid1_q      <= skid1_d;
         skid1_last_q <= skid1_last_d;
         skid_cnt_q   <= skid_cnt_d;
         out_data_q   <= out_data_d;
         out_vld_q    <= out_vld_d;
         out_last_q   <= out_last_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (wr_en) begin
         mem[wp_q] <= s_axis.tdata;
      end
      if (rd_en) begin
         rd_data_q <= mem[rp_q];
      end
   end

   assign s_axis.tready = 1'b1;
   assign m_axis.tdata  = out_data_q;
   assign m_axis.tvalid = out_vld_q;
   assign m_axis.tlast  = out_last_q;
   assign trig_o        = trig_q;
   assign busy_o        = busy_q;
endmodule
